// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, FSM state type and transfer helpers
// Contents: HTRANS/HRESP encodings, slave FSM state type, legality check
// and byte-lane mask helpers used by the register slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ERR1 = 2'd2;
    localparam state_t ST_ERR2 = 2'd3;

    // Out-of-range word, oversize, misaligned, or a write to the status word
    // (always the last register).
    function automatic logic xfer_illegal(input logic [31:0] addr,
                                          input logic [2:0]  size,
                                          input logic        write,
                                          input int          num_regs);
        logic [31:0] idx;
        logic [31:0] nregs;
        idx   = {2'b00, addr[31:2]};
        nregs = $unsigned(num_regs);
        xfer_illegal = (idx >= nregs) ||
                       (size > 3'd2) ||
                       ((size == 3'd1) && addr[0]) ||
                       ((size == 3'd2) && (addr[1:0] != 2'b00)) ||
                       (write && (idx == nregs - 32'd1));
    endfunction

    // Little-endian byte-lane enables for a legal transfer.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr,
                                             input logic [2:0] size);
        case (size)
            3'd0:    lane_mask = 4'b0001 << addr;
            3'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_reg_slave_if.sv
// rtl/ahb_reg_slave_if.sv - AHB slave-side bus bundle with master/slave modports
// Signals: HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, HMASTER,
// HMASTLOCK (master -> slave); HRDATA, HREADYOUT, HRESP (slave -> master).
interface ahb_reg_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, HMASTER, HMASTLOCK,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, HMASTER, HMASTLOCK,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_wait_counter.sv
// rtl/ahb_wait_counter.sv - loadable down-counter timing the WAIT state
// Ports: HCLK, HRESET (sync, active-high), load/load_val (start a wait of
// load_val cycles), done (high during the last wait cycle).
module ahb_wait_counter (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic       done
);
    logic [1:0] count;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            count <= 2'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 2'd0) begin
            count <= count - 2'd1;
        end
    end

    assign done = (count == 2'd1);
endmodule

// File: rtl/ahb_reg_slave.sv
// rtl/ahb_reg_slave.sv - AHB register slave with wait states, error response and status word
// Ports: HCLK, HRESET (sync, active-high), bus (ahb_reg_slave_if.slave).
// Parameters: NUM_REGS (2..16 words, last is read-only status),
// WAIT_STATES (0..3 stall cycles per OKAY transfer).
module ahb_reg_slave
    import ahb_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_reg_slave_if.slave   bus
);
    localparam int IW = $clog2(NUM_REGS);

    state_t        state, state_nxt;
    logic [31:0]   regs [NUM_REGS];

    // Captured data-phase attributes of the pending legal transfer.
    logic          dp_valid;
    logic          dp_write;
    logic [IW-1:0] dp_idx;
    logic [3:0]    dp_strb;

    logic hready_out, accept, illegal, legal_acc, complete, wait_done;

    // Ready in IDLE (possibly completing) and ERR2; a new address phase can
    // only be taken while we are ready, which gives back-to-back pipelining.
    assign hready_out = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept     = bus.HSEL && bus.HREADY && hready_out &&
                        ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
    assign illegal    = xfer_illegal(bus.HADDR, bus.HSIZE, bus.HWRITE, NUM_REGS);
    assign legal_acc  = accept && !illegal;
    assign complete   = dp_valid && (state == ST_IDLE);

    ahb_wait_counter u_wait (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .load     (legal_acc && (WAIT_STATES != 0)),
        .load_val (2'(WAIT_STATES)),
        .done     (wait_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (illegal)               state_nxt = ST_ERR1;
                    else if (WAIT_STATES != 0) state_nxt = ST_WAIT;
                    else                       state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: state_nxt = wait_done ? ST_IDLE : ST_WAIT;
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_strb  <= 4'b0000;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
        end else begin
            state <= state_nxt;
            // Status word is never a write target; writes to it are rejected.
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (complete && dp_write && (dp_idx == IW'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dp_strb[b]) regs[i][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                    end
                end
            end
            if (hready_out) dp_valid <= legal_acc;
            if (legal_acc) begin
                dp_write           <= bus.HWRITE;
                dp_idx             <= bus.HADDR[IW+1:2];
                dp_strb            <= lane_mask(bus.HADDR[1:0], bus.HSIZE);
                regs[NUM_REGS - 1] <= {23'h0, bus.HMASTLOCK, 4'h0, bus.HMASTER};
            end
        end
    end

    assign bus.HREADYOUT = hready_out;
    assign bus.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = (complete && !dp_write) ? regs[dp_idx] : 32'h0;
endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb/tb_ahb_reg_slave.sv - directed table-driven bench for ahb_reg_slave
module tb_ahb_reg_slave;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahb_reg_slave_if bus1 ();
    ahb_reg_slave_if bus0 ();

    logic        sel1, sel0, hready_en;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_trans;
    logic        m_write, m_lock;
    logic [2:0]  m_size;
    logic [3:0]  m_mst;

    assign bus1.HSEL = sel1;        assign bus0.HSEL = sel0;
    assign bus1.HADDR = m_addr;     assign bus0.HADDR = m_addr;
    assign bus1.HTRANS = m_trans;   assign bus0.HTRANS = m_trans;
    assign bus1.HWRITE = m_write;   assign bus0.HWRITE = m_write;
    assign bus1.HSIZE = m_size;     assign bus0.HSIZE = m_size;
    assign bus1.HWDATA = m_wdata;   assign bus0.HWDATA = m_wdata;
    assign bus1.HMASTER = m_mst;    assign bus0.HMASTER = m_mst;
    assign bus1.HMASTLOCK = m_lock; assign bus0.HMASTLOCK = m_lock;
    assign bus1.HREADY = bus1.HREADYOUT & hready_en;
    assign bus0.HREADY = bus0.HREADYOUT & hready_en;

    ahb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(1)) dut  (.HCLK(HCLK), .HRESET(HRESET), .bus(bus1));
    ahb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0));

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  mst;
        logic        lock;
        int          exp_waits;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One single transfer on bus0 (which=1) or bus1 (which=0); entered and
    // left just after a rising edge.
    task automatic xfer(input bit which, input vec_t v, input string tag);
        int   waits;
        bit   done;
        logic stall_resp, rdy;
        logic resp;
        logic [31:0] rdata;
        sel1 = !which; sel0 = which;
        m_trans = HTRANS_NONSEQ; m_addr = v.addr; m_write = v.wr; m_size = v.size;
        m_mst = v.mst; m_lock = v.lock; m_wdata = 32'h0;
        @(posedge HCLK); #1;
        sel1 = 1'b0; sel0 = 1'b0; m_trans = HTRANS_IDLE; m_wdata = v.wdata;
        waits = 0; done = 1'b0; stall_resp = 1'b0; resp = 1'b0; rdata = 32'h0;
        while (!done && waits < 8) begin
            @(negedge HCLK);
            rdy  = which ? bus0.HREADYOUT : bus1.HREADYOUT;
            resp = which ? bus0.HRESP : bus1.HRESP;
            if (rdy) begin
                done  = 1'b1;
                rdata = which ? bus0.HRDATA : bus1.HRDATA;
            end else begin
                if (waits == 0) stall_resp = resp;
                waits++;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got no HREADYOUT within 8 cycles, required completion", tag);
        end else begin
            check32({tag, " waits"}, 32'(waits), 32'(v.exp_waits));
            check32({tag, " resp"}, {31'h0, resp}, {31'h0, v.exp_resp});
            check32({tag, " rdata"}, rdata, v.exp_rdata);
            if (v.exp_waits > 0 && waits > 0)
                check32({tag, " stall resp"}, {31'h0, stall_resp}, {31'h0, v.exp_resp});
        end
        @(posedge HCLK); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check32({tag, " dut HREADYOUT"}, {31'h0, bus1.HREADYOUT}, 32'h1);
        check32({tag, " dut HRESP"}, {31'h0, bus1.HRESP}, 32'h0);
        check32({tag, " dut HRDATA"}, bus1.HRDATA, 32'h0);
    endtask

    initial begin
        HRESET = 1'b1; hready_en = 1'b1;
        sel1 = 1'b0; sel0 = 1'b0; m_trans = HTRANS_IDLE; m_addr = 32'h0; m_write = 1'b0;
        m_size = 3'd2; m_mst = 4'd0; m_lock = 1'b0; m_wdata = 32'h0;

        // Reset state
        @(posedge HCLK); @(negedge HCLK);
        check_idle_outputs("reset");
        check32("reset dut0 HREADYOUT", {31'h0, bus0.HREADYOUT}, 32'h1);
        @(posedge HCLK); #1; HRESET = 1'b0;

        // addr, wr, size, wdata, mst, lock, waits, resp, rdata   (WAIT_STATES=1)
        vecs.push_back(vec_t'{32'h00, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h04, 1'b1, 3'd2, 32'hDEADBEEF, 4'd0, 1'b0, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h06, 1'b1, 3'd0, 32'h00110000, 4'd0, 1'b0, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h04, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'hDE11BEEF});
        vecs.push_back(vec_t'{32'h20, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b1, 32'h0});
        vecs.push_back(vec_t'{32'h02, 1'b1, 3'd2, 32'hFFFFFFFF, 4'd0, 1'b0, 1, 1'b1, 32'h0});
        vecs.push_back(vec_t'{32'h1C, 1'b1, 3'd2, 32'hFFFFFFFF, 4'd0, 1'b0, 1, 1'b1, 32'h0});
        vecs.push_back(vec_t'{32'h08, 1'b1, 3'd3, 32'hFFFFFFFF, 4'd0, 1'b0, 1, 1'b1, 32'h0});
        vecs.push_back(vec_t'{32'h03, 1'b1, 3'd1, 32'hFFFFFFFF, 4'd0, 1'b0, 1, 1'b1, 32'h0});
        vecs.push_back(vec_t'{32'h0A, 1'b1, 3'd1, 32'hABCD0000, 4'd0, 1'b0, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h08, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'hABCD0000});
        vecs.push_back(vec_t'{32'h05, 1'b0, 3'd0, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'hDE11BEEF});
        vecs.push_back(vec_t'{32'h00, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h00, 1'b1, 3'd2, 32'h12345678, 4'd3, 1'b1, 1, 1'b0, 32'h0});
        vecs.push_back(vec_t'{32'h1C, 1'b0, 3'd2, 32'h0,        4'd3, 1'b1, 1, 1'b0, 32'h00000103});
        vecs.push_back(vec_t'{32'h1C, 1'b0, 3'd2, 32'h0,        4'd5, 1'b0, 1, 1'b0, 32'h00000005});
        vecs.push_back(vec_t'{32'h00, 1'b0, 3'd2, 32'h0,        4'd0, 1'b0, 1, 1'b0, 32'h12345678});

        foreach (vecs[i]) xfer(1'b0, vecs[i], $sformatf("vec%0d", i));

        // WAIT_STATES=0: three pipelined NONSEQ writes, HREADYOUT never drops
        sel0 = 1'b1; m_trans = HTRANS_NONSEQ; m_write = 1'b1; m_size = 3'd2;
        m_mst = 4'd0; m_lock = 1'b0; m_addr = 32'h0;
        @(posedge HCLK); #1; m_wdata = 32'h11111111; m_addr = 32'h4;
        @(negedge HCLK); check32("b2b ready0", {31'h0, bus0.HREADYOUT}, 32'h1);
        @(posedge HCLK); #1; m_wdata = 32'h22222222; m_addr = 32'h8;
        @(negedge HCLK); check32("b2b ready1", {31'h0, bus0.HREADYOUT}, 32'h1);
        @(posedge HCLK); #1; m_wdata = 32'h33333333; sel0 = 1'b0; m_trans = HTRANS_IDLE;
        @(negedge HCLK); check32("b2b ready2", {31'h0, bus0.HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        xfer(1'b1, vec_t'{32'h0, 1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 0, 1'b0, 32'h11111111}, "b2b rd0");
        xfer(1'b1, vec_t'{32'h4, 1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 0, 1'b0, 32'h22222222}, "b2b rd4");
        xfer(1'b1, vec_t'{32'h8, 1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 0, 1'b0, 32'h33333333}, "b2b rd8");

        // Address phase while HREADY=0 is ignored
        hready_en = 1'b0; sel0 = 1'b1; m_trans = HTRANS_NONSEQ; m_write = 1'b1; m_addr = 32'hC;
        @(posedge HCLK); #1;
        sel0 = 1'b0; m_trans = HTRANS_IDLE; m_wdata = 32'h0BAD0BAD; hready_en = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b1, vec_t'{32'hC, 1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 0, 1'b0, 32'h0}, "hready0 rdC");

        // Reset during WAIT of a write to 0x8 aborts the write
        sel1 = 1'b1; m_trans = HTRANS_NONSEQ; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h8;
        @(posedge HCLK); #1;
        sel1 = 1'b0; m_trans = HTRANS_IDLE; m_wdata = 32'hCAFEF00D; HRESET = 1'b1;
        @(negedge HCLK); check32("abort in wait", {31'h0, bus1.HREADYOUT}, 32'h0);
        @(posedge HCLK); #1; HRESET = 1'b0;
        @(negedge HCLK); check_idle_outputs("after abort");
        @(posedge HCLK); #1;
        xfer(1'b0, vec_t'{32'h8,  1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 1, 1'b0, 32'h0}, "abort rd8");
        xfer(1'b0, vec_t'{32'h4,  1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 1, 1'b0, 32'h0}, "abort rd4");
        xfer(1'b0, vec_t'{32'h1C, 1'b0, 3'd2, 32'h0, 4'd0, 1'b0, 1, 1'b0, 32'h0}, "abort rd1C");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no end of test, required finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
